ce_pulse_gen: RTL and testbench

Programmable clock-enable pulse generator that drives the `clk_en` input of the downstream `ff` register stage. On a `start` request it emits single-cycle `clk_en` strobes every `period` clock cycles. It either runs until `stop` or, when burst mode is compiled in, emits a fixed number of strobes and reports completion. This lets the register stage sample `d3` at a controlled, reduced rate without gating the clock.

---
 rtl/ce_pulse_gen.sv | 110 +++++++++++
 tb/tb_ce_pulse_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ce_pulse_gen.sv
// ce_pulse_gen: programmable clock-enable strobe generator for the ff stage; burst mode built when CE_PULSE_GEN_BURST_EN is defined
module ce_pulse_gen #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DIV_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               clk_en,
    output logic               busy,
    output logic               done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             strobe;
    logic             last;

    assign strobe = div_cnt_q == period_q - DIV_W'(1);

`ifdef CE_PULSE_GEN_BURST_EN
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] pulse_cnt_q, pulse_cnt_d;

    assign last = strobe && burst_q != '0 && pulse_cnt_q == burst_q - BURST_W'(1);

    // Latch the burst length at start and count issued strobes while running
    always_comb begin
        burst_d     = burst_q;
        pulse_cnt_d = pulse_cnt_q;
        if (state_q == IDLE) begin
            pulse_cnt_d = '0;
            if (start && !stop) burst_d = burst_len;
        end else if (state_q == RUN) begin
            pulse_cnt_d = stop ? '0 : strobe ? pulse_cnt_q + BURST_W'(1) : pulse_cnt_q;
        end
    end

    // Burst length and pulse counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q     <= '0;
            pulse_cnt_q <= '0;
        end else begin
            burst_q     <= burst_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end
`else
    logic unused_burst_len;

    assign unused_burst_len = ^burst_len;
    assign last             = 1'b0;
`endif

    // Sequencing: start latches the period, the divider issues a strobe every period_q cycles
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        div_cnt_d = div_cnt_q;
        clk_en_d  = 1'b0;
        if (state_q == IDLE) begin
            div_cnt_d = '0;
            if (start && !stop) begin
                state_d  = RUN;
                period_d = (period == '0) ? DIV_W'(1) : period;
            end
        end else if (state_q == RUN) begin
            if (stop) begin
                state_d   = IDLE;
                div_cnt_d = '0;
            end else if (strobe) begin
                clk_en_d  = 1'b1;
                div_cnt_d = '0;
                state_d   = last ? DONE : RUN;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            state_d = IDLE;
        end
    end

    // State, period latch, divider and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            period_q  <= '0;
            div_cnt_q <= '0;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            div_cnt_q <= div_cnt_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign clk_en = clk_en_q;
    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
endmodule

// File: tb/tb_ce_pulse_gen.sv
// tb_ce_pulse_gen: directed and random checks of ce_pulse_gen against a cycle-offset reference model
module tb_ce_pulse_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] period = 8'd0;
    logic [7:0] burst_len = 8'd0;
    logic       clk_en, busy, done;
    int         checks = 0;
    int         errors = 0;
    bit         mrun = 1'b0;
    int         k = 0;
    int         mp = 1;
    int         mn = 0;

    ce_pulse_gen #(.DIV_W(8), .BURST_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .period(period), .burst_len(burst_len),
        .clk_en(clk_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // k is the number of edges since the start edge; strobes land on multiples of the period
    task automatic check_all(input string tag);
        chk({tag, ".clk_en"}, clk_en, mrun && k >= 1 && (k % mp) == 0);
        chk({tag, ".busy"}, busy, mrun);
        chk({tag, ".done"}, done, mrun && mn != 0 && k == mn * mp);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        if (!rst_n) mrun = 1'b0;
        else if (!mrun) begin
            if (start && !stop) begin
                mrun = 1'b1;
                k    = 0;
                mp   = (period == 8'd0) ? 1 : int'(period);
`ifdef CE_PULSE_GEN_BURST_EN
                mn   = int'(burst_len);
`else
                mn   = 0;
`endif
            end
        end else if (stop) mrun = 1'b0;
        else begin
            k++;
            if (mn != 0 && k > mn * mp) mrun = 1'b0;
        end
        #1 check_all(tag);
    endtask

    initial begin
        start  = 1'b1;
        period = 8'd4;
        repeat (2) cyc("reset");
        @(negedge clk) rst_n = 1'b1;
        cyc("reset_start");
        start = 1'b0;
        stop  = 1'b1;
        cyc("reset_stop");
        stop = 1'b0;

        period    = 8'd4;
        burst_len = 8'd0;
        start     = 1'b1;
        cyc("periodic_start");
        start = 1'b0;
        repeat (13) cyc("periodic");
        stop = 1'b1;
        cyc("periodic_stop");
        stop = 1'b0;
        repeat (6) cyc("after_stop");

`ifdef CE_PULSE_GEN_BURST_EN
        period    = 8'd3;
        burst_len = 8'd3;
        start     = 1'b1;
        cyc("burst_start");
        start = 1'b0;
        repeat (8) cyc("burst");
        start = 1'b1;
        stop  = 1'b1;
        cyc("burst_last");
        cyc("burst_done");
        start = 1'b0;
        stop  = 1'b0;
        repeat (4) cyc("burst_after");
`else
        period    = 8'd2;
        burst_len = 8'd2;
        start     = 1'b1;
        cyc("noburst_start");
        start = 1'b0;
        repeat (12) cyc("noburst");
        stop = 1'b1;
        cyc("noburst_stop");
        stop = 1'b0;
`endif

        period    = 8'd0;
        burst_len = 8'd0;
        start     = 1'b1;
        cyc("p0_start");
        start = 1'b0;
        repeat (5) cyc("p0");
        period = 8'd5;
        repeat (5) cyc("p0_change");
        stop = 1'b1;
        cyc("p0_stop");

        start = 1'b1;
        cyc("start_stop");
        start = 1'b0;
        stop  = 1'b0;
        cyc("start_stop_idle");

        period = 8'd4;
        start  = 1'b1;
        cyc("arst_start");
        start = 1'b0;
        repeat (5) cyc("arst_run");
        #2 rst_n = 1'b0;
        mrun = 1'b0;
        #1 check_all("async_reset");
        @(negedge clk) rst_n = 1'b1;
        cyc("arst_release");

        repeat (400) begin
            start     = $urandom_range(0, 3) == 0;
            stop      = $urandom_range(0, 15) == 0;
            period    = 8'($urandom_range(0, 5));
            burst_len = 8'($urandom_range(0, 4));
            cyc("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
